// File: rtl/rst_sequencer.sv
// Power-on / re-arm reset sequencer: qualifies PLL lock, holds reset, then
// releases NCH active-high reset domains one at a time with a fixed gap.
`timescale 1ns/1ps
module rst_sequencer #(
   parameter int unsigned     NCH       = 3,
   parameter int unsigned     CNTW      = 22,
   parameter logic [CNTW-1:0] HOLD      = CNTW'(22'h3fffff),
   parameter logic [CNTW-1:0] STEP      = CNTW'(255),
   parameter int unsigned     LOCK_FILT = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pll_lock,
   input  logic           sw_rst,
   output logic [NCH-1:0] rst_out,
   output logic           ready,
   output logic [1:0]     state,
   output logic [1:0]     cause
);

   localparam int unsigned FW = $clog2(LOCK_FILT + 1);
   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_LOCK = 2'd1,
      CAUSE_SW   = 2'd2
   } cause_e;

   state_e          state_q, state_d;
   cause_e          cause_q, cause_d;
   logic [NCH-1:0]  rst_q, rst_d;
   logic            ready_q, ready_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [FW-1:0]   filt_q, filt_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            lock_s;

   assign lock_s = sync2_q;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      filt_d  = filt_q;
      sync1_d = pll_lock;
      sync2_d = sync1_q;

      if (state_q == ST_WAIT_LOCK) begin
         if (!lock_s) begin
            filt_d = '0;
         end else if (filt_q == FILT_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD;
            filt_d  = '0;
         end else begin
            filt_d = filt_q + 1'b1;
         end
      end else if (!lock_s) begin
         // lock loss outranks a concurrent software request
         state_d = ST_WAIT_LOCK;
         cause_d = CAUSE_LOCK;
         rst_d   = '1;
         ready_d = 1'b0;
         filt_d  = '0;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (sw_rst) begin
         state_d = ST_HOLD;
         cause_d = CAUSE_SW;
         rst_d   = '1;
         ready_d = 1'b0;
         cnt_d   = HOLD;
         idx_d   = '0;
      end else if (state_q == ST_HOLD) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            rst_d[0] = 1'b0;
            if (NCH == 1) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else begin
               state_d = ST_RELEASE;
               idx_d   = IW'(1);
               cnt_d   = STEP;
            end
         end
      end else if (state_q == ST_RELEASE) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (IW'(i) == idx_q) rst_d[i] = 1'b0;
            end
            if (idx_q == IDX_LAST) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
               cnt_d = STEP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT_LOCK;
         cause_q <= CAUSE_POR;
         rst_q   <= '1;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         filt_q  <= '0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         filt_q  <= filt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign rst_out = rst_q;
   assign ready   = ready_q;
   assign state   = state_q;
   assign cause   = cause_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the fixed 22-bit power-on reset counter in the top level.
- Qualifies the PLL lock with a synchroniser and a filter, then holds reset for a programmable time.
- Releases NCH active-high reset domains one at a time, with a programmable gap between releases (e.g. SYSTEM core first, then the peripheral/SPI domains).
- Re-arms on PLL lock loss or on a software reset request, and reports state and last reset cause.

Parameters:
- NCH, 3: number of reset domains (≥1).
- CNTW, 22: width of the hold/gap counter.
- HOLD, 22'h3fffff: cycles held after lock is qualified (fits CNTW).
- STEP, 255: cycles between consecutive domain releases (fits CNTW).
- LOCK_FILT, 4: consecutive synchronised-lock cycles required (≥1).

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-low block reset.
- pll_lock  in  1  raw PLL lock; may be asynchronous to clk.
- sw_rst  in  1  software reset request; synchronous to clk, level-sampled.
- rst_out  out  NCH  active-high reset per domain; bit 0 releases first.
- ready  out  1  high while all domains are released.
- state  out  2  0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN.
- cause  out  2  last reset cause: 0 power-on, 1 lock loss, 2 software.

Behaviour:
- Asynchronous reset (reset=0), applied immediately and independent of clk:
  - rst_out all ones, ready=0, state=WAIT_LOCK, cause=0.
  - counter=0, index=0, lock filter=0, both synchroniser flops=0.
- Lock synchroniser: 2 flops; lock_s is the second flop.
- WAIT_LOCK:
  - Filter increments on each edge where lock_s=1 and clears when lock_s=0.
  - On an edge where lock_s=1 and filter==LOCK_FILT-1: go to HOLD, counter=HOLD.
  - sw_rst is ignored here.
- HOLD:
  - Counter decrements each edge while nonzero.
  - On the edge where counter==0:
    - Clear rst_out[0].
    - If NCH==1: go to RUN.
    - Otherwise: go to RELEASE with index=1, counter=STEP.
- RELEASE:
  - Counter decrements each edge while nonzero.
  - On the edge where counter==0, clear rst_out[index].
  - If index==NCH-1: go to RUN. Otherwise: index+1, counter=STEP.
- RUN: ready=1. ready is registered and goes high on the same edge as the entry into RUN.
- Lock loss (lock_s=0 in HOLD/RELEASE/RUN):
  - Next edge: rst_out all ones, ready=0, cause=1, filter=0, go to WAIT_LOCK.
- Software reset (sw_rst=1 in HOLD/RELEASE/RUN with lock_s=1):
  - Next edge: rst_out all ones, ready=0, cause=2, go to HOLD with counter=HOLD.
  - sw_rst held high keeps reloading the counter; the release sequence starts only after sw_rst drops.
- Priority: lock loss over sw_rst over normal counting.
- Reset mid-sequence: everything returns to reset values asynchronously, with no partial release.
- Within one sequence, rst_out bits only go 1→0, strictly in index order; any return to 1 is all bits together.
- Timing reference: edge 0 is the first edge sampling pll_lock=1, with lock held steady.
  - HOLD is entered at edge 1+LOCK_FILT.
  - rst_out[0] falls at edge 2+LOCK_FILT+HOLD.
  - Each subsequent bit falls STEP+1 edges after the previous one.

Test Plan:
- Base parameters for all scenarios: NCH=3, HOLD=10, STEP=3, LOCK_FILT=4.
- Power-up: deassert reset, raise pll_lock and sample it at edge 0 -> state=1 at edge 5; rst_out 3'b110 at edge 16, 3'b100 at edge 20, 3'b000 with ready=1 and state=3 at edge 24; cause=0 throughout.
- Lock glitch: pll_lock high for 3 cycles, low for 1, then high -> filter restarts; HOLD is entered 4 lock_s-high cycles after the glitch clears; rst_out stays 3'b111 until then.
- Lock loss in RUN: drop pll_lock -> 2 edges later lock_s=0; next edge rst_out=3'b111, ready=0, state=0, cause=1; restoring lock repeats the power-up timeline.
- Software reset in RELEASE (rst_out=3'b110): pulse sw_rst for 1 cycle -> next edge rst_out=3'b111, state=1, cause=2; rst_out[0] falls 11 edges later; hold sw_rst for 5 cycles -> release delayed by those 5 cycles.
- Simultaneous lock loss and sw_rst in RUN -> cause=1, state=0.
- Async reset asserted mid-HOLD with no clk edge -> all outputs at reset values immediately.
- NCH=1 build -> HOLD goes directly to RUN; rst_out falls and ready rises on the same edge.
